// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg -- shared definitions for the writeback stage and its CP0.
//   MS_TO_WS_BUS_WD : width of the MEM->WB bus
//   ms_to_ws_bus_t  : field layout of that bus
//   exc_type_t      : compact exception type carried down the pipe
//   EXCCODE_*       : Cause.ExcCode values
//   CP0_*           : CP0 {rd, sel} addresses
//   EXC_VECTOR      : general exception entry point
package wb_stage_pkg;

  localparam int MS_TO_WS_BUS_WD = 85;

  typedef enum logic [2:0] {
    EXC_NONE   = 3'd0,
    EXC_SYS    = 3'd1,
    EXC_BP     = 3'd2,
    EXC_RI     = 3'd3,
    EXC_OV     = 3'd4,
    EXC_ADEL_D = 3'd5,
    EXC_ADES   = 3'd6,
    EXC_ADEL_F = 3'd7
  } exc_type_t;

  typedef struct packed {
    logic        bd;
    logic        eret;
    exc_type_t   exc_type;
    logic [7:0]  rd_sel;
    logic        res_from_cp0;
    logic        mtc0_we;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_bus_t;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0A;
  localparam logic [4:0] EXCCODE_OV   = 5'h0C;

  localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  // Maps a synchronous exception type to its Cause.ExcCode.
  function automatic logic [4:0] exc_code_of(input exc_type_t t);
    logic [4:0] code;
    case (t)
      EXC_SYS:    code = EXCCODE_SYS;
      EXC_BP:     code = EXCCODE_BP;
      EXC_RI:     code = EXCCODE_RI;
      EXC_OV:     code = EXCCODE_OV;
      EXC_ADEL_D: code = EXCCODE_ADEL;
      EXC_ADES:   code = EXCCODE_ADES;
      EXC_ADEL_F: code = EXCCODE_ADEL;
      default:    code = EXCCODE_INT;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/wb_stage_cp0_regs.sv
// cp0_regs -- CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC).
//   clk, reset          : clock, synchronous active-high reset
//   ext_int             : hardware interrupt lines -> Cause.IP[7:2]
//   exc_valid/code/bd/pc: exception commit from WB
//   badvaddr_we/val     : BadVAddr update on address errors
//   eret_valid          : eret commit (clears Status.EXL)
//   mtc0_valid/rd_sel/wdata : mtc0 write port
//   rdata               : read value of rd_sel (0 for unimplemented)
//   epc                 : current EPC (eret target)
//   int_pending         : unmasked interrupt pending
module cp0_regs
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  ext_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        exc_bd,
  input  logic [31:0] exc_pc,
  input  logic        badvaddr_we,
  input  logic [31:0] badvaddr_val,
  input  logic        eret_valid,
  input  logic        mtc0_valid,
  input  logic [7:0]  rd_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        int_pending
);

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [7:0]  cause_ip;
  logic [4:0]  cause_exccode;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] epc_q;
  logic [31:0] badvaddr;
  logic        tick;

  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic wr_count;
  logic wr_compare;

  always_comb begin
    wr_status  = mtc0_valid && (rd_sel == CP0_STATUS);
    wr_cause   = mtc0_valid && (rd_sel == CP0_CAUSE);
    wr_epc     = mtc0_valid && (rd_sel == CP0_EPC);
    wr_count   = mtc0_valid && (rd_sel == CP0_COUNT);
    wr_compare = mtc0_valid && (rd_sel == CP0_COMPARE);
  end

  // Status
  always_ff @(posedge clk) begin
    if (reset) begin
      status_im  <= '0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else if (exc_valid) begin
      status_exl <= 1'b1;
    end else if (eret_valid) begin
      status_exl <= 1'b0;
    end else if (wr_status) begin
      status_im  <= wdata[15:8];
      status_exl <= wdata[1];
      status_ie  <= wdata[0];
    end
  end

  // Cause: IP[7:2] tracks hardware lines (IP[7] shared with the timer),
  // IP[1:0] are software interrupts. Compare write beats a match.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_bd      <= 1'b0;
      cause_ti      <= 1'b0;
      cause_ip      <= '0;
      cause_exccode <= '0;
    end else begin
      cause_ip[7:2] <= {ext_int[5] | cause_ti, ext_int[4:0]};
      if (wr_cause)
        cause_ip[1:0] <= wdata[9:8];
      if (wr_compare)
        cause_ti <= 1'b0;
      else if (count == compare)
        cause_ti <= 1'b1;
      if (exc_valid) begin
        cause_exccode <= exc_code;
        if (!status_exl)
          cause_bd <= exc_bd;
      end
    end
  end

  // EPC is frozen while EXL is set so nested exceptions keep the first return point
  always_ff @(posedge clk) begin
    if (reset)
      epc_q <= '0;
    else if (exc_valid && !status_exl)
      epc_q <= exc_bd ? exc_pc - 32'd4 : exc_pc;
    else if (wr_epc)
      epc_q <= wdata;
  end

  // Count advances every other clock; a write restarts the half-rate phase
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (wr_count) begin
      count <= wdata;
      tick  <= 1'b0;
    end else begin
      tick <= ~tick;
      if (tick)
        count <= count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      compare <= '0;
    else if (wr_compare)
      compare <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)
      badvaddr <= '0;
    else if (badvaddr_we)
      badvaddr <= badvaddr_val;
  end

  always_comb begin
    rdata = '0;
    case (rd_sel)
      CP0_BADVADDR: rdata = badvaddr;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
      CP0_CAUSE:    rdata = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exccode, 2'b00};
      CP0_EPC:      rdata = epc_q;
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    epc         = epc_q;
    int_pending = status_ie && !status_exl && (|(cause_ip & status_im));
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage -- writeback stage: register-file write, exception/eret commit,
// pipeline flush and debug trace.
//   clk, reset                     : clock, synchronous active-high reset
//   ms_to_ws_valid, ms_to_ws_bus   : instruction from MEM
//   ext_int                        : hardware interrupt lines
//   ws_allowin, out_ws_valid       : handshake / stage valid
//   ws_fwd_dest                    : interlock destination (0 if not writing)
//   rf_we, rf_waddr, rf_wdata      : register-file write port
//   ws_flush, ws_flush_pc          : pipeline redirect
//   debug_wb_*                     : commit trace
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ws_allowin,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [5:0]                 ext_int,
  output logic                       out_ws_valid,
  output logic [4:0]                 ws_fwd_dest,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic                       ws_flush,
  output logic [31:0]                ws_flush_pc,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  logic          ws_valid;
  logic          ws_ready_go;
  ms_to_ws_bus_t ws_bus;

  logic          live;
  logic          int_pending;
  logic          ws_exc;
  logic [4:0]    exc_code;
  logic          badvaddr_we;
  logic [31:0]   badvaddr_val;
  logic          eret_valid;
  logic          mtc0_valid;
  logic [31:0]   cp0_rdata;
  logic [31:0]   cp0_epc;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = !ws_valid || ws_ready_go;

  always_ff @(posedge clk) begin
    if (reset)
      ws_valid <= 1'b0;
    else if (ws_flush)
      ws_valid <= 1'b0;
    else if (ws_allowin)
      ws_valid <= ms_to_ws_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ws_bus <= '0;
    else if (ms_to_ws_valid && ws_allowin)
      ws_bus <= ms_to_ws_bus;
  end

  // Reset masks the held instruction so an exception in WB during reset
  // neither flushes nor touches CP0.
  always_comb begin
    live         = ws_valid && !reset;
    ws_exc       = live && (int_pending || (ws_bus.exc_type != EXC_NONE));
    exc_code     = int_pending ? EXCCODE_INT : exc_code_of(ws_bus.exc_type);
    badvaddr_we  = ws_exc && !int_pending &&
                   (ws_bus.exc_type inside {EXC_ADEL_D, EXC_ADES, EXC_ADEL_F});
    badvaddr_val = (ws_bus.exc_type == EXC_ADEL_F) ? ws_bus.pc : ws_bus.final_result;
    eret_valid   = live && ws_bus.eret && !ws_exc;
    mtc0_valid   = live && ws_bus.mtc0_we && !ws_exc;
  end

  cp0_regs u_cp0 (
    .clk          (clk),
    .reset        (reset),
    .ext_int      (ext_int),
    .exc_valid    (ws_exc),
    .exc_code     (exc_code),
    .exc_bd       (ws_bus.bd),
    .exc_pc       (ws_bus.pc),
    .badvaddr_we  (badvaddr_we),
    .badvaddr_val (badvaddr_val),
    .eret_valid   (eret_valid),
    .mtc0_valid   (mtc0_valid),
    .rd_sel       (ws_bus.rd_sel),
    .wdata        (ws_bus.final_result),
    .rdata        (cp0_rdata),
    .epc          (cp0_epc),
    .int_pending  (int_pending)
  );

  always_comb begin
    out_ws_valid = live;
    ws_flush     = ws_exc || eret_valid;
    ws_flush_pc  = '0;
    if (ws_exc)
      ws_flush_pc = EXC_VECTOR;
    else if (eret_valid)
      ws_flush_pc = cp0_epc;

    rf_we       = live && ws_bus.gr_we && !ws_exc;
    rf_waddr    = reset ? '0 : ws_bus.dest;
    rf_wdata    = '0;
    if (!reset)
      rf_wdata = ws_bus.res_from_cp0 ? cp0_rdata : ws_bus.final_result;
    ws_fwd_dest = rf_we ? ws_bus.dest : '0;

    debug_wb_pc       = reset ? '0 : ws_bus.pc;
    debug_wb_rf_wen   = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end

endmodule
